// File: rtl/fmap_pkg.sv
// Shared definitions for the fmap capture block: default frame geometry,
// FSM state encoding and address-width derivation.
// No logic; imported by fmap_capture and fmap_frame_ram.
package fmap_pkg;

    localparam int FMAP_I_F_BW       = 8;
    localparam int FMAP_IX           = 28;
    localparam int FMAP_IY           = 28;
    localparam int FMAP_GAP_TIMEOUT  = 16;
    localparam int FMAP_TOTAL_PIXELS = FMAP_IX * FMAP_IY;

    // Address width for a memory of 'depth' entries (at least 1 bit).
    function automatic int fmap_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FMAP_AW = fmap_aw(FMAP_TOTAL_PIXELS);

    // Capture FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] fmap_state_t;
    localparam fmap_state_t ST_IDLE    = 2'd0;
    localparam fmap_state_t ST_CAPTURE = 2'd1;
    localparam fmap_state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/fmap_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Latency: read data 1 cycle after rd_addr; a same-address write returns old data.
// Backpressure: none, both ports accept every cycle.
module fmap_frame_ram
    import fmap_pkg::*;
#(
    parameter  int DW    = FMAP_I_F_BW,
    parameter  int DEPTH = FMAP_TOTAL_PIXELS,
    localparam int AW    = fmap_aw(DEPTH)
)(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read; non-blocking update gives read-before-write on collision.
    always_ff @(posedge clk) begin
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/fmap_capture.sv
// Captures one IX*IY raster frame from the fmap stream into a frame RAM, flags short/overrun frames.
// Latency: o_frame_done the cycle after the last beat; read port 1 cycle. Optional FMAP_CAPTURE_CHECKSUM_EN adds o_checksum.
// Backpressure: none, every i_valid beat is taken (beats arriving in DONE are dropped and flagged).
module fmap_capture
    import fmap_pkg::*;
#(
    parameter  int I_F_BW       = FMAP_I_F_BW,
    parameter  int IX           = FMAP_IX,
    parameter  int IY           = FMAP_IY,
    parameter  int GAP_TIMEOUT  = FMAP_GAP_TIMEOUT,
    localparam int TOTAL_PIXELS = IX * IY,
    localparam int AW           = fmap_aw(TOTAL_PIXELS)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [I_F_BW-1:0] i_pixel,
    input  logic              i_valid,
    input  logic              i_clr_err,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [I_F_BW-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_frame_valid,
    output logic              o_frame_done,
    output logic              o_err_short,
    output logic              o_err_overrun
`ifdef FMAP_CAPTURE_CHECKSUM_EN
    ,
    output logic [I_F_BW+AW-1:0] o_checksum
`endif
);

    localparam int              GW        = $clog2(GAP_TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(TOTAL_PIXELS - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_TIMEOUT - 1);
    localparam logic [AW:0]     DEPTH_W   = (AW+1)'(TOTAL_PIXELS);

    fmap_state_t       state;
    logic [AW-1:0]     wr_addr;
    logic [GW-1:0]     gap_cnt;
    logic              wr_en;
    logic              last_beat;
    logic              gap_expire;
    logic              overrun_beat;
    logic              rd_in_range_q;
    logic [I_F_BW-1:0] ram_rd_dat;

    // Per-cycle events decoded from the current state and stream strobe.
    always_comb begin
        wr_en        = i_valid && !reset && (state != ST_DONE);
        last_beat    = i_valid && (state == ST_CAPTURE) && (wr_addr == LAST_ADDR);
        gap_expire   = !i_valid && (state == ST_CAPTURE) && (gap_cnt == GAP_LAST);
        overrun_beat = i_valid && (state == ST_DONE);
    end

    assign o_busy = (state == ST_CAPTURE);

    // Capture FSM with write-address and idle-gap counters; wr_addr is 0 whenever IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wr_addr       <= '0;
            gap_cnt       <= '0;
            o_frame_valid <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        wr_addr       <= AW'(1);
                        gap_cnt       <= '0;
                        o_frame_valid <= 1'b0;
                        state         <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (i_valid) begin
                        gap_cnt <= '0;
                        if (last_beat) begin
                            wr_addr       <= '0;
                            o_frame_valid <= 1'b1;
                            o_frame_done  <= 1'b1;
                            state         <= ST_DONE;
                        end else begin
                            wr_addr <= wr_addr + AW'(1);
                        end
                    end else if (gap_expire) begin
                        // Partial frame abandoned; RAM keeps whatever was written.
                        gap_cnt <= '0;
                        wr_addr <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                ST_DONE: begin
                    // Stay here while beats keep coming so a back-to-back frame is rejected.
                    if (!i_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err_short   <= 1'b0;
            o_err_overrun <= 1'b0;
        end else begin
            o_err_short   <= gap_expire   || (o_err_short   && !i_clr_err);
            o_err_overrun <= overrun_beat || (o_err_overrun && !i_clr_err);
        end
    end

    fmap_frame_ram #(
        .DW    (I_F_BW),
        .DEPTH (TOTAL_PIXELS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (i_pixel),
        .rd_addr (i_rd_addr),
        .rd_dat  (ram_rd_dat)
    );

    // Track read-address range alongside the RAM read so out-of-range reads return 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_in_range_q <= 1'b0;
        end else begin
            rd_in_range_q <= ({1'b0, i_rd_addr} < DEPTH_W);
        end
    end

    assign o_rd_data = rd_in_range_q ? ram_rd_dat : '0;

`ifdef FMAP_CAPTURE_CHECKSUM_EN
    localparam int CW = I_F_BW + AW;
    logic [CW-1:0] sum_acc;

    // Running pixel sum; published only when a frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_acc    <= '0;
            o_checksum <= '0;
        end else if (i_valid && (state == ST_IDLE)) begin
            sum_acc <= CW'(i_pixel);
        end else if (i_valid && (state == ST_CAPTURE)) begin
            sum_acc <= sum_acc + CW'(i_pixel);
            if (last_beat) begin
                o_checksum <= sum_acc + CW'(i_pixel);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmap_capture.sv
// Directed bench for fmap_capture: full frames, short frame, overrun, gapped stream,
// mid-frame reset, out-of-range read and read/write collision.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_fmap_capture;

    localparam int I_F_BW = 8;
    localparam int TOTAL  = 28 * 28;
    localparam int AW     = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [I_F_BW-1:0] i_pixel;
    logic              i_valid;
    logic              i_clr_err;
    logic [AW-1:0]     i_rd_addr;
    logic [I_F_BW-1:0] o_rd_data;
    logic              o_busy;
    logic              o_frame_valid;
    logic              o_frame_done;
    logic              o_err_short;
    logic              o_err_overrun;
`ifdef FMAP_CAPTURE_CHECKSUM_EN
    logic [I_F_BW+AW-1:0] o_checksum;
`endif

    fmap_capture dut (
        .clk           (clk),
        .reset         (reset),
        .i_pixel       (i_pixel),
        .i_valid       (i_valid),
        .i_clr_err     (i_clr_err),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_busy        (o_busy),
        .o_frame_valid (o_frame_valid),
        .o_frame_done  (o_frame_done),
        .o_err_short   (o_err_short),
        .o_err_overrun (o_err_overrun)
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        ,
        .o_checksum    (o_checksum)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          done_cnt;
    logic [7:0]  mdl [TOTAL];
    logic [17:0] sum_mdl;
    logic [17:0] ck_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int a);
        int v;
        case (kind)
            0:       v = a;
            1:       v = a ^ 8'hA5;
            2:       v = a * 7 + 3;
            default: v = a * 13 + 1;
        endcase
        return v[7:0];
    endfunction

    task automatic beat(input logic [7:0] p);
        i_valid = 1'b1;
        i_pixel = p;
        tick();
        i_valid = 1'b0;
        if (o_frame_done) done_cnt++;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            tick();
            if (o_frame_done) done_cnt++;
        end
    endtask

    // Full contiguous frame; 'col' selects an address read in the same cycle it is written.
    task automatic send_frame(input string tag, input int kind, input int col);
        logic [7:0] p;
        logic [7:0] old;
        sum_mdl = '0;
        old     = '0;
        for (int a = 0; a < TOTAL; a++) begin
            p = pat(kind, a);
            if (a == col) begin
                i_rd_addr = a[AW-1:0];
                old       = mdl[a];
            end
            mdl[a]  = p;
            sum_mdl = sum_mdl + 18'(p);
            beat(p);
            if (a == 0) begin
                chk({tag, "_busy_first"}, o_busy, 1);
                chk({tag, "_fv_cleared"}, o_frame_valid, 0);
            end
            if (a == col) chk({tag, "_rw_collide_old"}, o_rd_data, old);
        end
        chk({tag, "_done_pulse"}, o_frame_done, 1);
        chk({tag, "_frame_valid"}, o_frame_valid, 1);
        ck_exp = sum_mdl;
    endtask

    task automatic readback(input string tag);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int a = 0; a < TOTAL; a++) begin
            i_rd_addr = a[AW-1:0];
            tick();
            if (o_rd_data !== mdl[a]) begin
                errs++;
                if (first < 0) first = a;
            end
        end
        chk({tag, "_readback_errs"}, errs, 0);
        if (errs != 0) $display("  first bad address %0d", first);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        i_valid   = 1'b0;
        i_pixel   = '0;
        i_clr_err = 1'b0;
        i_rd_addr = '0;
        done_cnt  = 0;
        ck_exp    = '0;
        tick();
        tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_valid", o_frame_valid, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_err_short", o_err_short, 0);
        chk("rst_err_overrun", o_err_overrun, 0);
        chk("rst_rd_data", o_rd_data, 0);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("rst_checksum", o_checksum, 0);
`endif
        reset = 1'b0;
        tick();

        // 1: contiguous frame, pixel = addr[7:0]
        done_cnt = 0;
        send_frame("t1", 0, -1);
        chk("t1_busy_in_done", o_busy, 0);
        idle(2);
        chk("t1_done_gone", o_frame_done, 0);
        chk("t1_done_count", done_cnt, 1);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t1_checksum", o_checksum, ck_exp);
`endif
        readback("t1");

        // 2: 400 beats then a 16-cycle gap aborts the frame
        done_cnt = 0;
        for (int a = 0; a < 400; a++) begin
            mdl[a] = pat(2, a);
            beat(mdl[a]);
            if (a == 0) chk("t2_fv_cleared", o_frame_valid, 0);
        end
        idle(15);
        chk("t2_no_err_at_15", o_err_short, 0);
        chk("t2_busy_at_15", o_busy, 1);
        idle(1);
        chk("t2_err_short", o_err_short, 1);
        chk("t2_idle", o_busy, 0);
        chk("t2_frame_valid", o_frame_valid, 0);
        chk("t2_no_done", done_cnt, 0);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t2_checksum_held", o_checksum, ck_exp);
`endif
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("t2_err_cleared", o_err_short, 0);

        // 3: 786 contiguous beats, the last two land in DONE
        done_cnt = 0;
        send_frame("t3", 1, -1);
        beat(8'h5A);
        chk("t3_overrun", o_err_overrun, 1);
        chk("t3_fv_kept", o_frame_valid, 1);
        chk("t3_busy", o_busy, 0);
        i_clr_err = 1'b1;
        beat(8'h77);
        i_clr_err = 1'b0;
        chk("t3_err_wins_clear", o_err_overrun, 1);
        idle(1);
        chk("t3_done_count", done_cnt, 1);
        chk("t3_fv_after_idle", o_frame_valid, 1);
        chk("t3_short_clear", o_err_short, 0);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t3_checksum", o_checksum, ck_exp);
`endif
        readback("t3");
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("t3_overrun_cleared", o_err_overrun, 0);

        // 4: random pixels with 1..15 idle cycles between beats
        done_cnt = 0;
        sum_mdl  = '0;
        for (int a = 0; a < TOTAL; a++) begin
            mdl[a]  = 8'($urandom_range(0, 255));
            sum_mdl = sum_mdl + 18'(mdl[a]);
            beat(mdl[a]);
            if (a != TOTAL - 1) idle($urandom_range(1, 15));
        end
        ck_exp = sum_mdl;
        chk("t4_done_pulse", o_frame_done, 1);
        chk("t4_frame_valid", o_frame_valid, 1);
        chk("t4_no_short", o_err_short, 0);
        idle(1);
        chk("t4_done_count", done_cnt, 1);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t4_checksum", o_checksum, ck_exp);
`endif
        readback("t4");

        // 5: reset asserted on beat 300 of a frame
        i_rd_addr = 10'd5;
        for (int a = 0; a < 299; a++) begin
            mdl[a] = pat(3, a);
            beat(mdl[a]);
        end
        chk("t5_busy_before", o_busy, 1);
        reset   = 1'b1;
        i_valid = 1'b1;
        i_pixel = 8'hEE;
        tick();
        i_valid = 1'b0;
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_frame_valid", o_frame_valid, 0);
        chk("t5_rst_frame_done", o_frame_done, 0);
        chk("t5_rst_err_short", o_err_short, 0);
        chk("t5_rst_err_overrun", o_err_overrun, 0);
        chk("t5_rst_rd_data", o_rd_data, 0);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t5_rst_checksum", o_checksum, 0);
`endif
        reset = 1'b0;
        tick();
        done_cnt = 0;
        send_frame("t5", 2, 10);
        idle(1);
        chk("t5_done_count", done_cnt, 1);
`ifdef FMAP_CAPTURE_CHECKSUM_EN
        chk("t5_checksum", o_checksum, ck_exp);
`endif
        readback("t5");

        // 6: out-of-range reads return 0
        i_rd_addr = 10'd784;
        tick();
        chk("t6_rd_784", o_rd_data, 0);
        i_rd_addr = 10'd783;
        tick();
        chk("t6_rd_783", o_rd_data, mdl[783]);
        i_rd_addr = 10'd1023;
        tick();
        chk("t6_rd_1023", o_rd_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
